// File: rtl/ssd_decode_monitor.sv
// ============================================================================
// ssd_decode_monitor
//
// Receive-side checker for a 3-bit seven-segment counter. The active-low
// segment bus is sampled every clock and debounced. Each stable pattern is
// decoded back to a digit 0..7. Patterns that are not in the digit table are
// flagged. Successive accepted digits are optionally checked against the
// counter's +1 mod 8 sequence. A saturating count of all flagged events is
// kept.
//
// Optional feature macro: SSD_SEQ_CHECK_EN
//   defined   - sequence checking is active; SEQ_ERR pulses on a bad step and
//               ERR_COUNT counts INVALID plus SEQ_ERR events.
//   undefined - sequence-check logic is absent; SEQ_ERR is tied low and
//               ERR_COUNT counts INVALID events only.
//
// Parameters:
//   STABLE_CYCLES  consecutive equal samples needed to accept a pattern (1..255)
//   ERR_W          width of ERR_COUNT
//
// Ports:
//   CLOCK      in   rising-edge clock for all logic
//   RESET      in   asynchronous reset, active low
//   SSD_IN     in   [6:0] segment bus, bit 6 = g .. bit 0 = a, active low
//   VALUE      out  [2:0] last accepted digit
//   VALID      out  one-cycle pulse when VALUE takes a new accepted digit
//   INVALID    out  one-cycle pulse when a stable pattern is not a digit
//   SEQ_ERR    out  one-cycle pulse when an accepted digit breaks +1 mod 8
//   LOCKED     out  a digit was accepted and no invalid pattern seen since
//   ERR_COUNT  out  [ERR_W-1:0] saturating count of error events
// ============================================================================
module ssd_decode_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [6:0]       SSD_IN,
    output logic [2:0]       VALUE,
    output logic             VALID,
    output logic             INVALID,
    output logic             SEQ_ERR,
    output logic             LOCKED,
    output logic [ERR_W-1:0] ERR_COUNT
);

    localparam logic [7:0]       STABLE_N  = 8'(STABLE_CYCLES);
    localparam logic [6:0]       BLANK     = 7'b1111111;
    localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

    // ------------------------------------------------------------------------
    // Sampling and debounce
    // ------------------------------------------------------------------------
    logic [6:0] sample_q;   // last registered segment pattern
    logic [7:0] run_cnt;    // length of the current run of equal samples
    logic       hit_q;      // run reached STABLE_N on the previous edge
    logic       same;
    logic [7:0] run_nxt;
    logic       hit_nxt;

    always_comb begin
        same    = (SSD_IN == sample_q);
        run_nxt = 8'd1;
        if (same) begin
            run_nxt = (run_cnt == STABLE_N) ? run_cnt : run_cnt + 8'd1;
        end
        // The run reaches its threshold on this edge only if it was not already
        // sitting saturated; a fresh run that loads 1 counts as reaching it when
        // STABLE_N is 1, which gives a decision on every change.
        hit_nxt = (run_nxt == STABLE_N) && (!same || (run_cnt != STABLE_N));
    end

    // NOTE: every piece of sequential state is written with non-blocking
    // assignments so all registers see the values from before the edge.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            sample_q <= BLANK;
            run_cnt  <= 8'd0;
            hit_q    <= 1'b0;
        end else begin
            sample_q <= SSD_IN;
            run_cnt  <= run_nxt;
            hit_q    <= hit_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Pattern decode. The pattern in sample_q is still the accepted one on the
    // edge after the run completes, because hit_q is only one edge behind.
    // ------------------------------------------------------------------------
    logic       dec_ok;
    logic [2:0] dec_val;

    // NOTE: both decode outputs get a default before the case so that no
    // pattern leaves them unassigned, which would infer latches.
    always_comb begin
        dec_ok  = 1'b1;
        dec_val = 3'd0;
        case (sample_q)
            7'b1000000: dec_val = 3'd0;
            7'b1111001: dec_val = 3'd1;
            7'b0100100: dec_val = 3'd2;
            7'b0110000: dec_val = 3'd3;
            7'b0011001: dec_val = 3'd4;
            7'b0010010: dec_val = 3'd5;
            7'b0000010: dec_val = 3'd6;
            7'b1111000: dec_val = 3'd7;
            default:    dec_ok  = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Acceptance decisions
    // ------------------------------------------------------------------------
    logic accept_invalid;
    logic accept_new;
    logic seq_pulse;
    logic err_inc;

    always_comb begin
        accept_invalid = hit_q && !dec_ok;
        // A stable return to the digit already shown while locked is a glitch
        // recovery, not a new digit.
        accept_new     = hit_q && dec_ok && !(LOCKED && (dec_val == VALUE));
`ifdef SSD_SEQ_CHECK_EN
        // Only judged while locked: the first digit after reset or after an
        // invalid pattern has no trustworthy predecessor.
        seq_pulse      = accept_new && LOCKED && (dec_val != VALUE + 3'd1);
`else
        seq_pulse      = 1'b0;
`endif
        // INVALID and SEQ_ERR never coincide, so one increment per cycle.
        err_inc        = accept_invalid || seq_pulse;
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            VALUE     <= 3'd0;
            VALID     <= 1'b0;
            INVALID   <= 1'b0;
            LOCKED    <= 1'b0;
            ERR_COUNT <= '0;
        end else begin
            VALID   <= accept_new;
            INVALID <= accept_invalid;
            if (accept_new) begin
                VALUE  <= dec_val;
                LOCKED <= 1'b1;
            end else if (accept_invalid) begin
                LOCKED <= 1'b0;
            end
            if (err_inc && (ERR_COUNT != ERR_MAX)) begin
                ERR_COUNT <= ERR_COUNT + ERR_ONE;
            end
        end
    end

`ifdef SSD_SEQ_CHECK_EN
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            SEQ_ERR <= 1'b0;
        end else begin
            SEQ_ERR <= seq_pulse;
        end
    end
`else
    assign SEQ_ERR = 1'b0;
`endif

endmodule
